output_tile_writer: RTL and testbench

OUTPUT_TILE_WRITER -- requirements
Module: output_tile_writer

---
 rtl/output_tile_writer.sv | 93 +++++++++
 tb/tb_output_tile_writer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/output_tile_writer.sv
// output_tile_writer: captures a multi-PE output tile and streams it word by word into a feature-map BRAM
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   i_tile_valid/i_tile_data tile handshake from the PE array (accepted when o_ready)
//   o_ready                 high in IDLE, a tile can be accepted
//   o_bram_en/we/addr/din   BRAM port-A write stream, NUM_PE*OUT_TILE^2 words per tile
//   o_frame_done            one-cycle pulse after the last tile of a frame
//   o_overflow              sticky, a tile arrived while busy and was dropped
// Optional: define OUT_RELU_EN to clamp negative elements to zero on write.
module output_tile_writer #(
  parameter int NUM_PE     = 3,
  parameter int OUT_TILE   = 2,
  parameter int ELEM_WIDTH = 28,
  parameter int OUT_W      = 8,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         i_tile_valid,
  input  logic [NUM_PE*OUT_TILE*OUT_TILE*ELEM_WIDTH-1:0] i_tile_data,
  output logic                                         o_ready,
  output logic                                         o_bram_en,
  output logic                                         o_bram_we,
  output logic [ADDR_WIDTH-1:0]                        o_bram_addr,
  output logic [ELEM_WIDTH-1:0]                        o_bram_din,
  output logic                                         o_frame_done,
  output logic                                         o_overflow
);
  localparam int NW  = NUM_PE * OUT_TILE * OUT_TILE;
  localparam int IW  = $clog2(NW + 1);
  localparam int TPR = OUT_W / OUT_TILE;
  localparam int TW  = TPR > 1 ? $clog2(TPR) : 1;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [NW*ELEM_WIDTH-1:0] tile_buf;
  logic [IW-1:0] idx, idx_nx;
  logic [TW-1:0] tcol, trow, tcol_nx, trow_nx;
  logic [ELEM_WIDTH-1:0] word, din;
  logic [ADDR_WIDTH-1:0] addr;
  logic accept, emit, last_word, last_col, last_tile;
  int w, pe, r, c;
  assign o_ready = state == IDLE;
  // Word 0 is taken straight from the input on the capture edge so the burst
  // starts one cycle after capture; later words come from the buffer.
  always_comb begin
    accept    = state == IDLE && i_tile_valid;
    last_word = state == WRITE && idx == IW'(NW);
    emit      = accept || (state == WRITE && !last_word);
    last_col  = tcol == TW'(TPR - 1);
    last_tile = last_col && trow == TW'(TPR - 1);
    w         = (accept || last_word) ? 0 : int'(idx);
    pe        = w / (OUT_TILE * OUT_TILE);
    r         = (w / OUT_TILE) % OUT_TILE;
    c         = w % OUT_TILE;
    word      = accept ? i_tile_data[w*ELEM_WIDTH +: ELEM_WIDTH] : tile_buf[w*ELEM_WIDTH +: ELEM_WIDTH];
`ifdef OUT_RELU_EN
    din       = word[ELEM_WIDTH-1] ? '0 : word;
`else
    din       = word;
`endif
    addr      = ADDR_WIDTH'(pe * OUT_W * OUT_W + (int'(trow) * OUT_TILE + r) * OUT_W + int'(tcol) * OUT_TILE + c);
    state_nx  = accept ? WRITE : last_word ? (last_tile ? DONE : IDLE) : state == DONE ? IDLE : state;
    idx_nx    = emit ? IW'(w + 1) : '0;
    tcol_nx   = last_word ? (last_col ? '0 : tcol + TW'(1)) : tcol;
    trow_nx   = (last_word && last_col) ? (last_tile ? '0 : trow + TW'(1)) : trow;
  end
  always_ff @(posedge clk)
    if (accept) tile_buf <= i_tile_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      tcol         <= '0;
      trow         <= '0;
      o_bram_en    <= 1'b0;
      o_bram_we    <= 1'b0;
      o_bram_addr  <= '0;
      o_bram_din   <= '0;
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      tcol         <= tcol_nx;
      trow         <= trow_nx;
      o_bram_en    <= emit;
      o_bram_we    <= emit;
      if (emit) o_bram_addr <= addr;
      if (emit) o_bram_din <= din;
      o_frame_done <= last_word && last_tile;
      o_overflow   <= o_overflow || (i_tile_valid && state != IDLE);
    end
endmodule

// File: tb/tb_output_tile_writer.sv
// tb_output_tile_writer: table-driven and randomized self-checking bench for output_tile_writer
module tb_output_tile_writer;
  localparam int NP = 3, OT = 2, EW = 28, OW = 8, AW = 15;
  localparam int NW = NP * OT * OT, DW = NW * EW, TPR = OW / OT, NT = TPR * TPR;
`ifdef OUT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif
  typedef struct {
    logic [EW-1:0] val;
    int unsigned   addr;
    logic [EW-1:0] din;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n;
  logic i_tile_valid;
  logic [DW-1:0] i_tile_data;
  logic o_ready, o_bram_en, o_bram_we, o_frame_done, o_overflow;
  logic [AW-1:0] o_bram_addr;
  logic [EW-1:0] o_bram_din;
  int checks = 0, errors = 0, tcnt = 0;
  bit ovf = 1'b0;
  int unsigned exp_a[NW];
  logic [EW-1:0] exp_d[NW];
  vec_t t1[NW], t2[NW];
  int unsigned base[NW] = '{0, 1, 8, 9, 64, 65, 72, 73, 128, 129, 136, 137};
  logic [EW-1:0] v2[NW] = '{28'hFFFFFFB, 28'd7, 28'h7FFFFFF, 28'h8000000, 28'hFFFFFFF, 28'd0,
                            28'd1, 28'hFFFFF9C, 28'd123456, 28'h4000000, 28'hFFFFFFE, 28'd42};
  output_tile_writer dut (
    .clk(clk), .reset_n(reset_n), .i_tile_valid(i_tile_valid), .i_tile_data(i_tile_data),
    .o_ready(o_ready), .o_bram_en(o_bram_en), .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr),
    .o_bram_din(o_bram_din), .o_frame_done(o_frame_done), .o_overflow(o_overflow)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  function automatic logic [EW-1:0] relu(input logic [EW-1:0] v);
    return (RELU && v[EW-1]) ? '0 : v;
  endfunction
  // Raster tile t of the frame, element e of the PE-major tile.
  function automatic int unsigned m_addr(input int t, input int e);
    int pe = e / (OT * OT), r = (e / OT) % OT, c = e % OT;
    int tr = t / TPR, tc = t % TPR;
    return (pe * OW * OW + (tr * OT + r) * OW + tc * OT + c) % (1 << AW);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic load_table(input bit second, output logic [DW-1:0] d);
    vec_t v;
    for (int e = 0; e < NW; e++) begin
      if (second) v = t2[e];
      else v = t1[e];
      d[e*EW +: EW] = v.val;
      exp_a[e] = v.addr;
      exp_d[e] = v.din;
    end
  endtask
  task automatic load_rand(output logic [DW-1:0] d);
    logic [EW-1:0] v;
    for (int e = 0; e < NW; e++) begin
      v = EW'($urandom);
      d[e*EW +: EW] = v;
      exp_a[e] = m_addr(tcnt, e);
      exp_d[e] = relu(v);
    end
  endtask
  // Sends one tile and checks the whole burst; ovf_at pulses a stray valid on
  // that write cycle, abort_after asserts reset once that many writes were seen.
  task automatic run_tile(input logic [DW-1:0] data, input int ovf_at, input int abort_after);
    int n = 0;
    bit done_exp;
    while (!o_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 64'(o_ready), 64'(1));
    done_exp = tcnt == NT - 1;
    i_tile_data = data;
    i_tile_valid = 1'b1;
    @(posedge clk); #1;
    i_tile_valid = 1'b0;
    i_tile_data = '0;
    for (int k = 0; k < NW; k++) begin
      chk("wr_en", 64'({o_bram_en, o_bram_we}), 64'(3));
      chk("wr_addr", 64'(o_bram_addr), 64'(exp_a[k]));
      chk("wr_din", 64'(o_bram_din), 64'(exp_d[k]));
      chk("busy_ready", 64'(o_ready), 64'(0));
      if (k + 1 == abort_after) begin
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_en", 64'({o_bram_en, o_bram_we}), 64'(0));
        chk("rst_addr_din", 64'({o_bram_addr, o_bram_din}), 64'(0));
        chk("rst_flags", 64'({o_frame_done, o_overflow}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
          @(posedge clk); #1;
          chk("post_rst_idle", 64'({o_bram_en, o_ready}), 64'(1));
        end
        tcnt = 0;
        ovf = 1'b0;
        return;
      end
      if (k == ovf_at) begin
        i_tile_valid = 1'b1;
        i_tile_data = ~data;
        ovf = 1'b1;
      end
      @(posedge clk); #1;
      i_tile_valid = 1'b0;
      i_tile_data = '0;
    end
    chk("end_en", 64'(o_bram_en), 64'(0));
    chk("frame_done", 64'(o_frame_done), 64'(done_exp));
    chk("end_ready", 64'(o_ready), 64'(!done_exp));
    chk("overflow", 64'(o_overflow), 64'(ovf));
    if (done_exp) begin
      @(posedge clk); #1;
      chk("done_clear", 64'(o_frame_done), 64'(0));
      chk("done_ready", 64'(o_ready), 64'(1));
    end
    tcnt = (tcnt + 1) % NT;
  endtask
  initial begin
    logic [DW-1:0] d;
    int gap, oa;
    for (int e = 0; e < NW; e++) begin
      t1[e] = '{EW'(e + 1), base[e], EW'(e + 1)};
      t2[e] = '{v2[e], base[e] + 2, relu(v2[e])};
    end
    reset_n = 1'b0;
    i_tile_valid = 1'b0;
    i_tile_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_en", 64'({o_bram_en, o_bram_we}), 64'(0));
    chk("reset_addr", 64'(o_bram_addr), 64'(0));
    chk("reset_din", 64'(o_bram_din), 64'(0));
    chk("reset_flags", 64'({o_frame_done, o_overflow}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 64'(o_ready), 64'(1));
    load_table(1'b0, d);
    run_tile(d, -1, -1);
    load_table(1'b1, d);
    run_tile(d, -1, -1);
    repeat (14) begin
      load_rand(d);
      run_tile(d, -1, -1);
    end
    load_rand(d);
    run_tile(d, -1, -1);
    load_rand(d);
    run_tile(d, 4, -1);
    load_rand(d);
    run_tile(d, -1, -1);
    load_rand(d);
    run_tile(d, -1, 6);
    load_table(1'b0, d);
    run_tile(d, -1, -1);
    repeat (30) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
        chk("gap_en", 64'(o_bram_en), 64'(0));
      end
      oa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NW - 1)) : -1;
      load_rand(d);
      run_tile(d, oa, -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
